seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle restoring divider in the calculator datapath, directly downstream of the expression controller.
- The controller issues a division when the popped operator is '/'.
- The divider produces one quotient bit per clock. Its latency is fixed, so the controller's division wait count stays deterministic.
- Quotient and remainder feed the result register and are pushed back onto the operand stack.

Parameters:
- WIDTH, 16, operand/result width in bits; latency equals WIDTH iterations.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  WIDTH  numerator (op1); captured on an accepted start.
- divisor  input  WIDTH  denominator (op2); captured on an accepted start.
- quotient  output  WIDTH  result quotient; held until the next completion.
- remainder  output  WIDTH  result remainder; held until the next completion.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results update.
- div_by_zero  output  1  flag for the last completed division; held with the results.

Behaviour:
- Reset (async, rst=1): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; iteration counter=0; internal operand registers=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge E0 latches dividend/divisor into internal registers and clears the partial remainder.
  - Counter=0, go to RUN; busy=1 from E0.
- RUN (WIDTH cycles), each edge:
  - Shift the {partial remainder, dividend} pair left by 1.
  - Trial-subtract the divisor from the WIDTH+1-bit partial remainder.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments. At the edge where counter==WIDTH-1 (edge E_WIDTH): go to FIN, busy=0, done=1, quotient/remainder/div_by_zero update.
- FIN (1 cycle):
  - done=1 and the results are valid.
  - Next edge returns to IDLE and clears done.
  - start=1 in FIN is accepted as in IDLE (back-to-back), and done still drops.
- Latency: start edge E0 → done high after edge E_WIDTH (16 cycles at the default). This matches the controller's 16-cycle division wait.
- start while busy=1: ignored; operands are not recaptured.
- Input changes during RUN have no effect; operands are registered.
- Divisor=0 (checked on the captured value):
  - Runs the full WIDTH cycles (fixed latency).
  - Result: quotient = all ones, remainder = dividend, div_by_zero=1.
- Dividend < divisor: quotient=0, remainder=dividend.
- Results and div_by_zero hold their last values until the next completion; they are not cleared by start.
- rst asserted mid-RUN: immediately returns to IDLE with all outputs zeroed; the partial result is discarded.
- Arithmetic: unsigned by default; the partial remainder is WIDTH+1 bits to hold the trial-subtraction sign.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. On capture, magnitudes are taken and the result signs are recorded.
  - The unsigned core runs unchanged. At FIN the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend (truncation toward zero).
  - Overflow case (most negative / -1): quotient = most negative value (wraps), remainder = 0, div_by_zero=0.
  - Divide by zero: quotient = -1 (all ones), remainder = dividend.
  - Latency is unchanged.
- Not defined: pure unsigned operation; no sign logic is synthesised.

Test Plan:
- Reset then idle: rst pulse mid-cycle (async) → quotient=0, remainder=0, busy=0, done=0 immediately; no done with start=0 for 40 cycles.
- Basic: dividend=100, divisor=7, start 1 cycle → busy=1 for 16 cycles, done pulse exactly 16 edges after the start edge, quotient=14, remainder=2, div_by_zero=0.
- Zero divisor: dividend=0x1234, divisor=0 → done at 16 cycles, quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
- Busy rejection and back-to-back:
  - Start 50/5; pulse start with 9/3 at cycle 5 → ignored, result 10 rem 0.
  - Start 9/3 in the FIN cycle → accepted, second done 16 cycles later with 3 rem 0.
- Reset mid-operation: start 65535/1, assert rst at cycle 8 → all outputs 0 immediately; a following start 65535/1 gives 65535 rem 0.
- Signed (SEQ_DIVIDER_SIGNED_EN): -7/2 → quotient=-3 (0xFFFD), remainder=-1 (0xFFFF); 0x8000/0xFFFF → quotient=0x8000, remainder=0.

Source files
------------

// File: rtl/seq_divider_if.sv
// Handshake/result bundle between the expression controller and seq_divider.
// The controller (master) drives start and operands; the divider (slave)
// returns results, status and a debug view of its FSM state.
`timescale 1ns/1ps
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    // Handshake: start is sampled on a rising clk edge only while busy=0
    // (IDLE or FIN). An accepted start registers dividend/divisor; busy is
    // high for exactly WIDTH cycles. done pulses for one cycle with the new
    // quotient/remainder/div_by_zero, which then hold until the next done.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [1:0]       state_dbg;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, state_dbg
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, state_dbg
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, fixed latency of
// WIDTH cycles from the accepting edge to done. Unsigned by default.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's complement operands, handled by
// dividing magnitudes and fixing signs at completion (truncation toward zero).
`timescale 1ns/1ps
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd_r;      // dividend, shifted out MSB-first; quotient shifts in
    logic [WIDTH-1:0] dsr_r;      // captured divisor
    logic [WIDTH-1:0] rem_r;      // partial remainder (always < divisor)
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_keep;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] cap_dvd;
    logic [WIDTH-1:0] cap_dsr;
    logic             accept;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_r;                // operand signs differ
    logic neg_r_r;                // dividend was negative
`endif

    // One restoring iteration plus capture/final-correction values.
    always_comb begin
        rem_shift = {rem_r, dvd_r[WIDTH-1]};
        trial     = rem_shift - {1'b0, dsr_r};
        q_bit     = ~trial[WIDTH];
        rem_keep  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        dvd_step  = {dvd_r[WIDTH-2:0], q_bit};
        accept    = bus.start && (state != RUN);
`ifdef SEQ_DIVIDER_SIGNED_EN
        cap_dvd   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        cap_dsr   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        // A zero divisor keeps the all-ones quotient; the remainder sign fix
        // turns |dividend| back into the original dividend.
        q_fin     = (neg_q_r && (dsr_r != '0)) ? -dvd_step : dvd_step;
        r_fin     = neg_r_r ? -rem_keep : rem_keep;
`else
        cap_dvd   = bus.dividend;
        cap_dsr   = bus.divisor;
        q_fin     = dvd_step;
        r_fin     = rem_keep;
`endif
    end

    // Control FSM and datapath registers; outputs are all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            rem_r       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FIN: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        dvd_r  <= cap_dvd;
                        dsr_r  <= cap_dsr;
                        rem_r  <= '0;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q_r <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r_r <= bus.dividend[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    dvd_r <= dvd_step;
                    rem_r <= rem_keep;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient_r  <= q_fin;
                        remainder_r <= r_fin;
                        dbz_r       <= (dsr_r == '0);
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= FIN;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand-written corner
// sequences (latency, busy rejection, back-to-back, async reset), random
// divisions against a behavioural model. Results are matched through a queue.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int W  = 16;
  localparam int EW = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t          vecs[$];
  logic [EW-1:0] exp_q[$];   // {div_by_zero, quotient, remainder}
  logic [EW-1:0] mon_e;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            done_count = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Behavioural model of one division.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    int ia;
    int ib;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SEQ_DIVIDER_SIGNED_EN
    ia = int'($signed(a));
    ib = int'($signed(b));
    q  = W'(ia / ib);
    r  = W'(ia % ib);
`else
    ia = int'(a);
    ib = int'(b);
    q  = W'(ia / ib);
    r  = W'(ia % ib);
`endif
    return {1'b0, q, r};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always begin
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 q=%h r=%h, required no pending result",
                 bus.quotient, bus.remainder);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {bus.div_by_zero, bus.quotient, bus.remainder}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive start for one edge (E0); returns #1 after E0 with start low.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [EW-1:0] e, input bit push);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges after E0 until done, scrambling operand inputs meanwhile.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      bus.dividend = W'($urandom_range(0, 65535));
      bus.divisor  = W'($urandom_range(0, 65535));
    end
    check(name, EW'(n), EW'(16));
    check({name, "_busy_low"}, EW'(bus.busy), EW'(0));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("reset_results", {1'b0, bus.quotient, bus.remainder}, '0);
    check("reset_status", EW'({bus.busy, bus.done, bus.div_by_zero, bus.state_dbg}), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle: no done without start
    done_count = 0;
    repeat (40) @(posedge clk);
    #1;
    check("idle_no_done", EW'(done_count), EW'(0));
    check("idle_busy", EW'(bus.busy), EW'(0));

    // Vector table
    vecs.push_back('{a:16'd100,   b:16'd7,   q:16'd14,   r:16'd2,    dbz:1'b0});
    vecs.push_back('{a:16'h1234,  b:16'h0,   q:16'hFFFF, r:16'h1234, dbz:1'b1});
    vecs.push_back('{a:16'd5,     b:16'd9,   q:16'd0,    r:16'd5,    dbz:1'b0});
    vecs.push_back('{a:16'd0,     b:16'd5,   q:16'd0,    r:16'd0,    dbz:1'b0});
    vecs.push_back('{a:16'd1000,  b:16'd10,  q:16'd100,  r:16'd0,    dbz:1'b0});
    vecs.push_back('{a:16'd12345, b:16'd256, q:16'd48,   r:16'd57,   dbz:1'b0});
    vecs.push_back('{a:16'h7FFF,  b:16'd2,   q:16'h3FFF, r:16'd1,    dbz:1'b0});
    vecs.push_back('{a:16'hFFFF,  b:16'd1,   q:16'hFFFF, r:16'd0,    dbz:1'b0});
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{a:16'hFFF9,  b:16'd2,    q:16'hFFFD, r:16'hFFFF, dbz:1'b0});
    vecs.push_back('{a:16'h8000,  b:16'hFFFF, q:16'h8000, r:16'h0000, dbz:1'b0});
    vecs.push_back('{a:16'h0007,  b:16'hFFFE, q:16'hFFFD, r:16'h0001, dbz:1'b0});
    vecs.push_back('{a:16'hFFF9,  b:16'hFFFE, q:16'h0003, r:16'hFFFF, dbz:1'b0});
    vecs.push_back('{a:16'hFFFB,  b:16'h0000, q:16'hFFFF, r:16'hFFFB, dbz:1'b1});
`else
    vecs.push_back('{a:16'hFFFF,  b:16'hFFFF, q:16'd1,    r:16'd0,    dbz:1'b0});
    vecs.push_back('{a:16'hFFFF,  b:16'h8000, q:16'd1,    r:16'h7FFF, dbz:1'b0});
    vecs.push_back('{a:16'd60000, b:16'd7,    q:16'd8571, r:16'd3,    dbz:1'b0});
`endif
    foreach (vecs[i]) begin
      start_div(vecs[i].a, vecs[i].b, {vecs[i].dbz, vecs[i].q, vecs[i].r}, 1'b1);
      check("start_busy", EW'(bus.busy), EW'(1));
      wait_done("latency");
    end

    // Zero-divide results hold across the next start
    start_div(16'h1234, 16'h0000, {1'b1, 16'hFFFF, 16'h1234}, 1'b1);
    wait_done("dbz_latency");
    start_div(16'd100, 16'd7, {1'b0, 16'd14, 16'd2}, 1'b1);
    check("hold_after_start", {bus.div_by_zero, bus.quotient, bus.remainder},
          {1'b1, 16'hFFFF, 16'h1234});
    wait_done("hold_latency");

    // Busy rejection, then back-to-back start in FIN
    start_div(16'd50, 16'd5, {1'b0, 16'd10, 16'd0}, 1'b1);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (n == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
      end
      if (n == 5) bus.start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_reject_latency", EW'(n), EW'(16));
    bus.start    = 1'b1;
    bus.dividend = 16'd9;
    bus.divisor  = 16'd3;
    exp_q.push_back({1'b0, 16'd3, 16'd0});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_done_drops", EW'(bus.done), EW'(0));
    check("b2b_busy", EW'(bus.busy), EW'(1));
    wait_done("b2b_latency");

    // Asynchronous reset mid-run discards the division
    start_div(16'hFFFF, 16'd1, '0, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_results", {1'b0, bus.quotient, bus.remainder}, '0);
    check("rst_mid_status", EW'({bus.busy, bus.done, bus.div_by_zero, bus.state_dbg}), '0);
    @(negedge clk);
    rst = 1'b0;
    start_div(16'hFFFF, 16'd1, {1'b0, 16'hFFFF, 16'd0}, 1'b1);
    wait_done("post_rst_latency");

    // Random divisions against the model
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 65535));
      start_div(ra, rb, model(ra, rb), 1'b1);
      wait_done("rand_latency");
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_empty", EW'(exp_q.size()), EW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
